// File: rtl/concat_ctrl.sv
// Sequencer/arbiter feeding the shift-concatenation stage: grants header then payload
// segments in message order, forwards them one register stage later, and tracks words emitted.
module concat_ctrl #(
    parameter int HDR_WORDS = 2,
    parameter int WCNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [63:0]       hdr_data,
    input  logic [6:0]        hdr_bits,
    input  logic              hdr_valid,
    output logic              hdr_ready,
    input  logic [63:0]       pay_data,
    input  logic [6:0]        pay_bits,
    input  logic              pay_valid,
    input  logic              pay_last,
    output logic              pay_ready,
    output logic [63:0]       cat_data,
    output logic [6:0]        cat_bits,
    output logic              cat_valid,
    output logic              cat_msg_fin,
    output logic              cat_stall,
    input  logic              cat_done,
    input  logic              out_ready,
    output logic              busy,
    output logic [WCNT_W-1:0] word_count,
    output logic              msg_done,
    output logic              bits_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_PAY, S_FIN, S_DRAIN, S_DONE
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  hdr_cnt;
    logic        drain_min;
    logic        hdr_acc, pay_acc, seg_acc, seg_fwd, seg_bad, msg_start;
    logic [63:0] seg_data;
    logic [6:0]  seg_bits;

    assign cat_stall = ~out_ready;
    assign busy      = (state != S_IDLE);
    assign hdr_ready = out_ready && (state == S_HDR);
    assign pay_ready = out_ready && (state == S_PAY);
    assign hdr_acc   = hdr_valid && hdr_ready;
    assign pay_acc   = pay_valid && pay_ready;
    assign seg_acc   = hdr_acc || pay_acc;
    assign seg_data  = hdr_acc ? hdr_data : pay_data;
    assign seg_bits  = hdr_acc ? hdr_bits : pay_bits;
    // Zero-length and oversize segments are consumed but never reach the concatenator.
    assign seg_fwd   = seg_acc && (seg_bits != 7'd0) && (seg_bits <= 7'd64);
    assign seg_bad   = seg_acc && (seg_bits > 7'd64);
    assign msg_start = (state == S_IDLE) && start;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_HDR;
            S_HDR:   if (hdr_acc && hdr_cnt == 4'(HDR_WORDS - 1)) state_nx = S_PAY;
            S_PAY:   if (pay_acc && pay_last) state_nx = S_FIN;
            S_FIN:   if (out_ready) state_nx = S_DRAIN;
            // Second unstalled DRAIN cycle onward, leave once the concatenator is quiet.
            S_DRAIN: if (out_ready && drain_min && !cat_done) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            hdr_cnt     <= '0;
            drain_min   <= 1'b0;
            cat_data    <= '0;
            cat_bits    <= '0;
            cat_valid   <= 1'b0;
            cat_msg_fin <= 1'b0;
            word_count  <= '0;
            msg_done    <= 1'b0;
            bits_err    <= 1'b0;
        end else begin
            msg_done <= (state == S_DRAIN) && (state_nx == S_DONE);
            // DONE is the only state that moves on regardless of backpressure.
            if (out_ready || state == S_DONE)
                state <= state_nx;
            if (out_ready) begin
                cat_valid   <= seg_fwd;
                cat_msg_fin <= (state == S_FIN);
                drain_min   <= (state == S_DRAIN);
                if (seg_fwd) begin
                    cat_data <= seg_data;
                    cat_bits <= seg_bits;
                end
                if (msg_start)
                    hdr_cnt <= '0;
                else if (hdr_acc)
                    hdr_cnt <= hdr_cnt + 4'd1;
                if (msg_start)
                    word_count <= '0;
                else if (busy && cat_done && !(&word_count))
                    word_count <= word_count + 1'b1;
                if (msg_start)
                    bits_err <= 1'b0;
                else if (seg_bad)
                    bits_err <= 1'b1;
            end
        end
    end

endmodule
